// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and sizing helper for the segment-to-binary path.
package seg7_pkg;

  // Segment patterns in {a,b,c,d,e,f,g} order, a is bit 6.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } state_t;

  // Bits needed to hold 10^n_digits - 1 without truncation.
  function automatic int unsigned acc_width(input int unsigned n_digits);
    longint unsigned lim;
    int unsigned     w;
    lim = 1;
    for (int unsigned i = 0; i < n_digits; i++) begin
      lim = lim * 10;
    end
    w = 0;
    for (int unsigned b = 63; b > 0; b--) begin
      if ((longint'(1) << b) >= lim) begin
        w = b;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational decode of one 7-segment pattern to BCD with an illegal-pattern flag.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  // Table lookup; blank reads as zero, anything unlisted is flagged.
  always_comb begin
    bcd = '0;
    err = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = 4'd0;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_2_bin.sv
// Captures a multi-digit 7-segment word and folds it MSD-first into a saturated binary value.
module seg7_2_bin
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned OUT_W    = 12
) (
  input  logic                CLK_i,
  input  logic                RST_i,
  input  logic [N_DIGITS-1:0] SEGa_i,
  input  logic [N_DIGITS-1:0] SEGb_i,
  input  logic [N_DIGITS-1:0] SEGc_i,
  input  logic [N_DIGITS-1:0] SEGd_i,
  input  logic [N_DIGITS-1:0] SEGe_i,
  input  logic [N_DIGITS-1:0] SEGf_i,
  input  logic [N_DIGITS-1:0] SEGg_i,
  input  logic                VALID_i,
  output logic                READY_o,
  output logic [OUT_W-1:0]    OUT_o,
  output logic                ERR_o,
  output logic                OVF_o,
  output logic                VALID_o,
  input  logic                READY_i
);

  localparam int unsigned ACC_W   = acc_width(N_DIGITS);
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(N_DIGITS - 1);
  localparam logic [63:0] MAX_OUT = (64'd1 << OUT_W) - 64'd1;

  state_t                state;
  logic [6:0]            seg_q [N_DIGITS];
  logic [3:0]            bcd [N_DIGITS];
  logic [N_DIGITS-1:0]   dig_err;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_next;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            bcd_sel;
  logic                  err_sel;
  logic                  ovf_next;
  logic [OUT_W-1:0]      out_q;
  logic                  err_q;
  logic                  ovf_q;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dec
    seg7_digit_dec u_dec (
      .seg (seg_q[i]),
      .bcd (bcd[i]),
      .err (dig_err[i])
    );
  end

  // Select the current digit and form the next accumulator value (acc*10 as shift-add).
  always_comb begin
    bcd_sel  = bcd[idx];
    err_sel  = dig_err[idx];
    acc_next = (acc << 3) + (acc << 1) + ACC_W'(bcd_sel);
    ovf_next = (64'(acc_next) > MAX_OUT);
  end

  // Handshake FSM: capture in IDLE, one digit per cycle in CONV, present result in HOLD.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      out_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        seg_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (VALID_i) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
              seg_q[i] <= {SEGa_i[i], SEGb_i[i], SEGc_i[i], SEGd_i[i],
                           SEGe_i[i], SEGf_i[i], SEGg_i[i]};
            end
            acc   <= '0;
            idx   <= IDX_MSD;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            state <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_next;
          err_q <= err_q | err_sel;
          if (idx == '0) begin
            // Result is taken from acc_next so it lands on the same edge as HOLD entry.
            ovf_q <= ovf_next;
            out_q <= ovf_next ? '1 : OUT_W'(acc_next);
            state <= HOLD;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        HOLD: begin
          if (READY_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign READY_o = (state == IDLE);
  assign VALID_o = (state == HOLD);
  assign OUT_o   = out_q;
  assign ERR_o   = err_q;
  assign OVF_o   = ovf_q;

endmodule

// File: tb/tb_seg7_2_bin.sv
// Scoreboard bench for seg7_2_bin: table cases, backpressure, mid-conversion reset, full loopback.
module tb_seg7_2_bin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [11:0] out_val;
  logic        err_out;
  logic        ovf_out;
  logic        valid_out;
  logic        ready_in = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  logic prev_v = 1'b0;

  typedef struct {
    int out;
    int err;
    int ovf;
    int acc_cyc;
  } exp_t;
  exp_t sb[$];

  seg7_2_bin #(.N_DIGITS(4), .OUT_W(12)) dut (
    .CLK_i   (clk),
    .RST_i   (rst),
    .SEGa_i  (seg_a),
    .SEGb_i  (seg_b),
    .SEGc_i  (seg_c),
    .SEGd_i  (seg_d),
    .SEGe_i  (seg_e),
    .SEGf_i  (seg_f),
    .SEGg_i  (seg_g),
    .VALID_i (valid_in),
    .READY_o (ready_out),
    .OUT_o   (out_val),
    .ERR_o   (err_out),
    .OVF_o   (ovf_out),
    .VALID_o (valid_out),
    .READY_i (ready_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // {a,b,c,d,e,f,g}; any value outside 0..9 gives a blank digit.
  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0][6:0] mk(input int d3, input int d2, input int d1, input int d0);
    logic [3:0][6:0] w;
    w[3] = enc(d3);
    w[2] = enc(d2);
    w[1] = enc(d1);
    w[0] = enc(d0);
    return w;
  endfunction

  // Binary-to-segment encoder with leading-zero blanking, used for loopback.
  function automatic logic [3:0][6:0] enc_value(input int v);
    logic [3:0][6:0] w;
    bit lead;
    int p;
    int d;
    lead = 1'b1;
    p = 1000;
    for (int i = 3; i >= 0; i--) begin
      d = (v / p) % 10;
      if (lead && d == 0 && i != 0) begin
        w[i] = 7'b0000000;
      end else begin
        lead = 1'b0;
        w[i] = enc(d);
      end
      p = p / 10;
    end
    return w;
  endfunction

  task automatic apply_word(input logic [3:0][6:0] w);
    for (int i = 0; i < 4; i++) begin
      {seg_a[i], seg_b[i], seg_c[i], seg_d[i], seg_e[i], seg_f[i], seg_g[i]} = w[i];
    end
  endtask

  // Called at posedge+1; offers one word and records its expectation at the accept edge.
  task automatic send(input logic [3:0][6:0] w, input int e_out, input int e_err,
                      input int e_ovf, input bit push);
    int t;
    t = 0;
    while (!ready_out && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ready_out) begin
      check_eq("ready_timeout", 0, 1);
      return;
    end
    apply_word(w);
    valid_in = 1'b1;
    @(posedge clk); #1;
    if (push) sb.push_back('{e_out, e_err, e_ovf, cycle});
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !ready_out) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain_done", (sb.size() == 0 && ready_out) ? 1 : 0, 1);
  endtask

  // Output monitor: latency on VALID rise, value compare on each completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out && !prev_v) begin
        if (sb.size() != 0) check_eq("latency", cycle - sb[0].acc_cyc, 4);
        else check_eq("unexpected_valid", 1, 0);
      end
      if (valid_out && ready_in && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out", out_val, e.out);
        check_eq("err", err_out, e.err);
        check_eq("ovf", ovf_out, e.ovf);
      end
    end
    prev_v <= valid_out;
  end

  initial begin
    logic [3:0][6:0] w;
    logic [11:0] h_out;
    logic h_err;
    logic h_ovf;
    int t;

    apply_word(mk(10, 10, 10, 10));
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_ready", ready_out, 1);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_out", out_val, 0);
    check_eq("rst_err", err_out, 0);
    check_eq("rst_ovf", ovf_out, 0);
    rst = 1'b0;

    send(mk(4, 0, 9, 5), 4095, 0, 0, 1'b1);
    drain();
    send(mk(9, 9, 9, 9), 4095, 0, 1, 1'b1);
    drain();
    send(mk(10, 10, 10, 7), 7, 0, 0, 1'b1);
    drain();
    w = mk(1, 2, 10, 4);
    w[1] = 7'b0000001;
    send(w, 1204, 1, 0, 1'b1);
    drain();

    // Backpressure: result must hold while new words are offered.
    ready_in = 1'b0;
    send(mk(0, 0, 4, 2), 42, 0, 0, 1'b1);
    t = 0;
    while (!valid_out && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("hold_valid_seen", valid_out, 1);
    h_out = out_val;
    h_err = err_out;
    h_ovf = ovf_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      valid_in = ~valid_in;
      apply_word(mk($urandom_range(0, 9), $urandom_range(0, 9), 9, 9));
      check_eq("hold_ready", ready_out, 0);
      check_eq("hold_valid", valid_out, 1);
      check_eq("hold_out", out_val, h_out);
      check_eq("hold_err", err_out, h_err);
      check_eq("hold_ovf", ovf_out, h_ovf);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    check_eq("release_ready", ready_out, 1);
    check_eq("release_valid", valid_out, 0);
    drain();

    // Reset during the second conversion cycle discards the word.
    send(mk(5, 5, 5, 5), 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_ready", ready_out, 1);
    check_eq("midrst_valid", valid_out, 0);
    check_eq("midrst_out", out_val, 0);
    check_eq("midrst_err", err_out, 0);
    send(mk(0, 1, 2, 3), 123, 0, 0, 1'b1);
    drain();

    // Full loopback through the reference encoder.
    for (int v = 0; v < 4096; v++) begin
      send(enc_value(v), v, 0, 0, 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
